// File: rtl/frame_pkg.sv
// Frame geometry and capture-state encoding shared by the frame-memory
// write and read paths.
package frame_pkg;

    localparam int FRAME_W       = 320;
    localparam int FRAME_H       = 240;
    localparam int FRAME_PIXELS  = FRAME_W * FRAME_H;
    localparam int PIX_PER_BLOCK = 16;
    localparam int NUM_BLOCKS    = FRAME_PIXELS / PIX_PER_BLOCK;
    localparam int PIXEL_W       = 8;
    localparam int BLOCK_W       = PIXEL_W * PIX_PER_BLOCK;
    localparam int BLK_ADDR_W    = 13;
    localparam int PIX_ADDR_W    = 17;
    localparam int PIX_CNT_W     = PIX_ADDR_W;
    localparam int LANE_W        = $clog2(PIX_PER_BLOCK);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } frameState_t;

    // Next block address, wrapping after the last block of the frame.
    function automatic logic [BLK_ADDR_W-1:0] nextBlkAddr(input logic [BLK_ADDR_W-1:0] addr);
        if (addr == BLK_ADDR_W'(NUM_BLOCKS - 1))
            return '0;
        return addr + 1'b1;
    endfunction

endpackage

// File: rtl/pixel_block_writer_packer.sv
// Collects pixels into one memory word; the first pixel of a block ends up
// in the least-significant byte.
module pixel_packer
    import frame_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               load,
    input  logic [PIXEL_W-1:0] pixData,
    output logic               blockFull,
    output logic [BLOCK_W-1:0] blockWord
);

    localparam int HOLD_W = BLOCK_W - PIXEL_W;

    logic [LANE_W-1:0] laneCnt;
    logic [LANE_W-1:0] laneEff;
    logic [HOLD_W-1:0] shiftReg;

    // A clear restarts the block at lane 0, even when a pixel loads together with it.
    assign laneEff   = clear ? '0 : laneCnt;
    assign blockFull = load && (laneEff == LANE_W'(PIX_PER_BLOCK - 1));
    assign blockWord = {pixData, shiftReg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            laneCnt  <= '0;
            shiftReg <= '0;
        end else if (load) begin
            laneCnt  <= laneEff + 1'b1;
            shiftReg <= {pixData, shiftReg[HOLD_W-1:PIXEL_W]};
        end else if (clear) begin
            laneCnt  <= '0;
        end
    end

endmodule

// File: rtl/pixel_block_writer.sv
// Packs the camera pixel stream into 16-pixel blocks and writes them to the
// frame BRAM, flagging frame completion and stream protocol errors.
module pixel_block_writer
    import frame_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  pix_valid,
    input  logic [PIXEL_W-1:0]    pix_data,
    output logic                  wr_en,
    output logic [BLK_ADDR_W-1:0] wr_addr,
    output logic [BLOCK_W-1:0]    wr_data,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  overflow,
    output logic                  short_frame
);

    localparam logic [PIX_CNT_W-1:0] LAST_PIX = PIX_CNT_W'(FRAME_PIXELS - 1);

    frameState_t           state;
    logic [PIX_CNT_W-1:0]  pixCnt;
    logic [PIX_CNT_W-1:0]  pixEff;
    logic [BLK_ADDR_W-1:0] blkAddr;
    logic [BLK_ADDR_W-1:0] blkEff;
    logic                  accept;
    logic                  restart;
    logic                  lastPix;
    logic                  blockFull;
    logic [BLOCK_W-1:0]    blockWord;

    // A restart inside CAPTURE takes effect on the same cycle so the
    // accompanying pixel becomes pixel 0 of the new frame.
    assign restart = frame_start && (state == CAPTURE);
    assign accept  = pix_valid && (state == CAPTURE);
    assign pixEff  = restart ? '0 : pixCnt;
    assign blkEff  = restart ? '0 : blkAddr;
    assign lastPix = accept && (pixEff == LAST_PIX);

    pixel_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (frame_start),
        .load      (accept),
        .pixData   (pix_data),
        .blockFull (blockFull),
        .blockWord (blockWord)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pixCnt      <= '0;
            blkAddr     <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
            overflow    <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;

            if (pix_valid && (state != CAPTURE))
                overflow <= 1'b1;

            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state   <= CAPTURE;
                        busy    <= 1'b1;
                        pixCnt  <= '0;
                        blkAddr <= '0;
                    end
                end
                CAPTURE: begin
                    if (restart) begin
                        short_frame <= 1'b1;
                        pixCnt      <= '0;
                        blkAddr     <= '0;
                    end
                    if (accept)
                        pixCnt <= pixEff + 1'b1;
                    if (lastPix)
                        state <= DONE;
                end
                DONE: begin
                    frame_done <= 1'b1;
                    if (frame_start) begin
                        state   <= CAPTURE;
                        pixCnt  <= '0;
                        blkAddr <= '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Block write; the address update overrides the restart clear above.
            if (blockFull) begin
                wr_en   <= 1'b1;
                wr_addr <= blkEff;
                wr_data <= blockWord;
                blkAddr <= nextBlkAddr(blkEff);
            end
        end
    end

endmodule
